irq_latch_ctrl: RTL and testbench

IRQ_LATCH_CTRL -- requirements
Module: irq_latch_ctrl

---
 rtl/irq_pkg.sv | 9 +
 rtl/irq_prio_enc.sv | 15 +
 rtl/irq_latch_ctrl.sv | 60 ++++++
 tb/tb_irq_latch_ctrl.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// irq_pkg: shared FSM state type, defaults and vector helper for the interrupt latch controller
package irq_pkg;
  typedef enum logic [1:0] {IDLE, REQ, CLR} irq_state_e;
  localparam int NSRC_DEF = 5;
  localparam logic [7:0] VEC_BASE_DEF = 8'h40;
  function automatic logic [7:0] vec_of(input logic [7:0] base, input int idx);
    return base + 8'(idx * 8);
  endfunction
endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: lowest-set-bit priority encoder with valid flag
module irq_prio_enc #(
  parameter int N = 5,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         valid
);
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) if (req[i]) idx = W'(i);
  end
  assign valid = |req;
endmodule

// File: rtl/irq_latch_ctrl.sv
// irq_latch_ctrl: edge-set interrupt flag latches with enable mask and IDLE/REQ/CLR acknowledge FSM
module irq_latch_ctrl
  import irq_pkg::*;
#(
  parameter int         NSRC     = NSRC_DEF,
  parameter logic [7:0] VEC_BASE = VEC_BASE_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src_req,
  input  logic            bus_wr_if,
  input  logic            bus_wr_ie,
  input  logic [NSRC-1:0] bus_wdata,
  input  logic            cpu_ack,
  output logic [NSRC-1:0] if_q,
  output logic [NSRC-1:0] ie_q,
  output logic            irq_pending,
  output logic [7:0]      irq_vector,
  output logic            ack_done
);
  localparam int SW = (NSRC > 1) ? $clog2(NSRC) : 1;
  irq_state_e state, state_n;
  logic [NSRC-1:0] src_prev, edges, if_n;
  logic [SW-1:0] sel, enc_idx;
  logic enc_valid;
  assign edges = src_req & ~src_prev;
  // set edges dominate; a bus write overrides the acknowledge clear
  assign if_n = (bus_wr_if ? bus_wdata : (state == CLR ? if_q & ~(NSRC'(1) << sel) : if_q)) | edges;
  irq_prio_enc #(.N(NSRC), .W(SW)) u_enc (
    .req  (if_q & ie_q),
    .idx  (enc_idx),
    .valid(enc_valid)
  );
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      if_q     <= '0;
      ie_q     <= '0;
      src_prev <= src_req;
      sel      <= '0;
    end else begin
      if_q     <= if_n;
      ie_q     <= bus_wr_ie ? bus_wdata : ie_q;
      src_prev <= src_req;
      sel      <= (state == IDLE && enc_valid) ? enc_idx : sel;
    end
  end
  always_comb begin
    state_n = state == IDLE ? (enc_valid ? REQ : IDLE) :
              state == REQ  ? (cpu_ack ? CLR : REQ) : IDLE;
  end
  always_comb begin
    irq_pending = state == REQ;
    irq_vector  = irq_pending ? vec_of(VEC_BASE, int'(sel)) : 8'h00;
    ack_done    = state == CLR;
  end
endmodule

// File: tb/tb_irq_latch_ctrl.sv
// tb_irq_latch_ctrl: table vectors, directed corner sequences and random stimulus against a behavioural model
module tb_irq_latch_ctrl;
  localparam int N = 5;
  logic clk = 1'b0, reset = 1'b1;
  logic [N-1:0] src_req = '0, bus_wdata = '0;
  logic bus_wr_if = 1'b0, bus_wr_ie = 1'b0, cpu_ack = 1'b0;
  logic [N-1:0] if_q, ie_q;
  logic irq_pending, ack_done;
  logic [7:0] irq_vector;
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  irq_latch_ctrl dut (
    .clk(clk), .reset(reset), .src_req(src_req), .bus_wr_if(bus_wr_if), .bus_wr_ie(bus_wr_ie),
    .bus_wdata(bus_wdata), .cpu_ack(cpu_ack), .if_q(if_q), .ie_q(ie_q),
    .irq_pending(irq_pending), .irq_vector(irq_vector), .ack_done(ack_done)
  );
  // reference model: flags/mask as vectors, cur = committed source (-1 none), acking = clear cycle
  logic [N-1:0] m_if = '0, m_ie = '0, m_prev = '0;
  int m_cur = -1;
  bit m_acking = 1'b0;
  function automatic int lowest(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction
  task automatic cyc(input logic r, input logic wif, input logic wie, input logic [N-1:0] wd,
                     input logic [N-1:0] rq, input logic a);
    logic [N-1:0] e, nif;
    reset = r; bus_wr_if = wif; bus_wr_ie = wie; bus_wdata = wd; src_req = rq; cpu_ack = a;
    if (r) begin
      m_if = '0; m_ie = '0; m_prev = rq; m_cur = -1; m_acking = 1'b0;
    end else begin
      e = rq & ~m_prev;
      nif = m_if;
      if (m_acking) nif[m_cur] = 1'b0;
      if (wif) nif = wd;
      nif = nif | e;
      if (m_acking) begin m_acking = 1'b0; m_cur = -1; end
      else if (m_cur >= 0) begin if (a) m_acking = 1'b1; end
      else m_cur = lowest(m_if & m_ie);
      if (wie) m_ie = wd;
      m_if = nif;
      m_prev = rq;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [19:0] got, input logic [19:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %05h expected %05h (if,ie,pend,vec,ack)", nm, got, exp);
  endtask
  function automatic logic [19:0] dut_out();
    return {if_q, ie_q, irq_pending, irq_vector, ack_done};
  endfunction
  function automatic logic [19:0] model_out();
    logic p;
    logic [7:0] v;
    p = m_cur >= 0 && !m_acking;
    v = p ? 8'(8'h40 + 8 * m_cur) : 8'h00;
    return {m_if, m_ie, p, v, m_acking};
  endfunction
  typedef struct {
    logic wif, wie;
    logic [N-1:0] wd, rq;
    logic a;
    logic [N-1:0] eif, eie;
    logic ep;
    logic [7:0] ev;
    logic ea;
  } vec_t;
  vec_t tbl[10];
  initial begin
    tbl[0] = '{1'b0, 1'b1, 5'b00001, 5'b00000, 1'b0, 5'b00000, 5'b00001, 1'b0, 8'h00, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 5'b00000, 5'b00001, 1'b0, 5'b00001, 5'b00001, 1'b0, 8'h00, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 5'b00000, 5'b00001, 1'b0, 5'b00001, 5'b00001, 1'b1, 8'h40, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 5'b00000, 5'b00001, 1'b1, 5'b00001, 5'b00001, 1'b0, 8'h00, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 5'b00000, 5'b00001, 1'b0, 5'b00000, 5'b00001, 1'b0, 8'h00, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 5'b00100, 5'b00001, 1'b0, 5'b00100, 5'b00001, 1'b0, 8'h00, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 5'b00100, 5'b00001, 1'b0, 5'b00100, 5'b00100, 1'b0, 8'h00, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 5'b00000, 5'b00001, 1'b0, 5'b00100, 5'b00100, 1'b1, 8'h50, 1'b0};
    tbl[8] = '{1'b0, 1'b0, 5'b00000, 5'b00001, 1'b1, 5'b00100, 5'b00100, 1'b0, 8'h00, 1'b1};
    tbl[9] = '{1'b0, 1'b0, 5'b00000, 5'b00001, 1'b0, 5'b00000, 5'b00100, 1'b0, 8'h00, 1'b0};
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("reset_state", dut_out(), 20'h0);
    for (int i = 0; i < 10; i++) begin
      cyc(0, tbl[i].wif, tbl[i].wie, tbl[i].wd, tbl[i].rq, tbl[i].a);
      chk($sformatf("tbl%0d", i), dut_out(),
          {tbl[i].eif, tbl[i].eie, tbl[i].ep, tbl[i].ev, tbl[i].ea});
    end
    // two simultaneous edges: source 2 served first, source 4 after one idle cycle
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 5'b11111, 0, 0);
    cyc(0, 0, 0, 0, 5'b10100, 0);
    chk("dual_if", {15'h0, if_q}, {15'h0, 5'b10100});
    cyc(0, 0, 0, 0, 5'b10100, 0);
    chk("dual_vec2", {11'h0, irq_pending, irq_vector}, {11'h0, 1'b1, 8'h50});
    cyc(0, 0, 0, 0, 5'b10100, 1);
    chk("dual_ack", {19'h0, ack_done}, 20'h1);
    cyc(0, 0, 0, 0, 5'b10100, 0);
    chk("dual_gap", {11'h0, irq_pending, irq_vector}, 20'h0);
    cyc(0, 0, 0, 0, 5'b10100, 0);
    chk("dual_vec4", {11'h0, irq_pending, irq_vector}, {11'h0, 1'b1, 8'h60});
    // set edge during the clear cycle of source 1 keeps the flag and re-presents it
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 5'b00010, 0, 0);
    cyc(0, 0, 0, 0, 5'b00010, 0);
    cyc(0, 0, 0, 0, 5'b00010, 0);
    chk("clr_edge_req", {11'h0, irq_pending, irq_vector}, {11'h0, 1'b1, 8'h48});
    cyc(0, 0, 0, 0, 5'b00000, 1);
    chk("clr_edge_ack", {15'h0, if_q}, {15'h0, 5'b00010});
    chk("clr_edge_pulse", {19'h0, ack_done}, 20'h1);
    cyc(0, 0, 0, 0, 5'b00010, 0);
    chk("clr_edge_keep", {15'h0, if_q}, {15'h0, 5'b00010});
    cyc(0, 0, 0, 0, 5'b00010, 0);
    chk("clr_edge_again", {11'h0, irq_pending, irq_vector}, {11'h0, 1'b1, 8'h48});
    // bus write during the clear cycle wins over the acknowledge clear
    cyc(0, 0, 0, 0, 5'b00010, 1);
    cyc(0, 1, 0, 5'b00011, 5'b00010, 0);
    chk("clr_bus_wr", {15'h0, if_q}, {15'h0, 5'b00011});
    // reset in REQ with all sources held high: no edges on exit
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 5'b11111, 0, 0);
    cyc(0, 0, 0, 0, 5'b11111, 0);
    cyc(0, 0, 0, 0, 5'b11111, 0);
    chk("rst_pre", {11'h0, irq_pending, irq_vector}, {11'h0, 1'b1, 8'h40});
    cyc(1, 0, 0, 0, 5'b11111, 0);
    chk("rst_in_req", dut_out(), 20'h0);
    cyc(0, 0, 1, 5'b11111, 5'b11111, 0);
    cyc(0, 0, 0, 0, 5'b11111, 0);
    cyc(0, 0, 0, 0, 5'b11111, 0);
    chk("rst_no_edge", {14'h0, if_q, irq_pending}, 20'h0);
    cyc(0, 0, 0, 0, 5'b10111, 0);
    cyc(0, 0, 0, 0, 5'b11111, 0);
    chk("rst_reedge", {15'h0, if_q}, {15'h0, 5'b01000});
    // random traffic against the model
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      logic [N-1:0] tog;
      tog = N'($urandom & $urandom & $urandom);
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
          N'($urandom), src_req ^ tog, $urandom_range(0, 2) == 0);
      chk($sformatf("rand%0d", i), dut_out(), model_out());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
